// File: rtl/ysyx_22051013_fetch_ctrl_if.sv
// Fetch controller bus: the instruction-memory request/response channel,
// the decode handoff, and the PC-select inputs.
interface ysyx_22051013_fetch_ctrl_if #(
    parameter int PC_W   = 64,
    parameter int INST_W = 32
);
    logic [PC_W-1:0]   pc_next;
    logic              redirect;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              if_valid;
    logic [PC_W-1:0]   if_pc;
    logic [INST_W-1:0] if_inst;
    logic              id_ready;

    // Fetch controller side
    modport master (
        input  pc_next, redirect, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
        output imem_req_valid, imem_addr, if_valid, if_pc, if_inst
    );

    // Memory / decode / PC-select side
    modport slave (
        output pc_next, redirect, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
        input  imem_req_valid, imem_addr, if_valid, if_pc, if_inst
    );
endinterface

// File: rtl/ysyx_22051013_fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request at a time,
// discards responses made stale by a redirect, and holds the fetched
// instruction for decode until it is accepted or squashed.
module ysyx_22051013_fetch_ctrl #(
    parameter int              PC_W     = 64,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h8000_0000)
) (
    input  logic clk,
    input  logic rst_n,
    ysyx_22051013_fetch_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              pc_load;
    logic              inst_load;

    // State, PC and instruction buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
            inst  <= '0;
        end else begin
            state <= state_next;
            if (pc_load) begin
                pc <= bus.pc_next;
            end
            if (inst_load) begin
                inst <= bus.imem_rsp_data;
            end
        end
    end

    // Next-state, PC update and capture decisions
    always_comb begin
        state_next = state;
        pc_load    = 1'b0;
        inst_load  = 1'b0;
        unique case (state)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                if (bus.redirect) begin
                    // Unaccepted request may retarget; an accepted one leaves a stale response behind
                    pc_load    = 1'b1;
                    state_next = bus.imem_req_ready ? DROP : REQ;
                end else if (bus.imem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.redirect) begin
                    pc_load    = 1'b1;
                    state_next = bus.imem_rsp_valid ? REQ : DROP;
                end else if (bus.imem_rsp_valid) begin
                    inst_load  = 1'b1;
                    state_next = HOLD;
                end
            end
            DROP: begin
                if (bus.redirect) begin
                    pc_load = 1'b1;
                end
                if (bus.imem_rsp_valid) begin
                    state_next = REQ;
                end
            end
            HOLD: begin
                if (bus.redirect || bus.id_ready) begin
                    pc_load    = 1'b1;
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.imem_req_valid = (state == REQ);
    assign bus.if_valid       = (state == HOLD);
    assign bus.imem_addr      = pc;
    assign bus.if_pc          = pc;
    assign bus.if_inst        = inst;

endmodule
